song_sample_player: RTL
=======================

Name: song_sample_player

Overview:
- Parametrised sample-playback engine for stored songs.
- Steps a ROM address through a programmable [start, end] window at a divided sample rate and presents each ROM word as the current audio sample.
- Adds explicit play/pause/stop control, single-shot or loop mode, an end-of-track flag and a sample strobe.
- Sits between the song ROM and the audio output stage; drives the ROM address and registers the ROM data.

Parameters:
- ADDR_W, 15, ROM address width.
- DATA_W, 4, sample width.
- CLK_DIV, 3125, system clocks per sample tick; legal range 2 to 2^16-1.

Ports:
- clk50Mghz  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: latch the window and play from track_start.
- stop  in  1  one-cycle pulse: abort and go to IDLE.
- pause  in  1  level: while high, playback freezes.
- loop_en  in  1  level, sampled at each end-of-track: 1 = wrap to start, 0 = finish.
- track_start  in  ADDR_W  first sample address, latched on start.
- track_end  in  ADDR_W  last sample address (inclusive), latched on start.
- rom_addr  out  ADDR_W  address to song ROM.
- rom_data  in  DATA_W  ROM word; valid one cycle after rom_addr changes.
- sample  out  DATA_W  current audio sample.
- sample_stb  out  1  one-cycle pulse when sample updates.
- playing  out  1  high in PLAY and PAUSE.
- done  out  1  one-cycle pulse when a single-shot track finishes.

Behaviour:
- Reset values: state IDLE, rom_addr 0, divider 0, sample 0, sample_stb 0, playing 0, done 0, latched start/end 0.
- States: IDLE, PLAY, PAUSE, DONE.
- Priority when several controls are active in one cycle: rst > stop > start > pause.
- start from any state:
  - latch track_start and track_end;
  - set rom_addr to track_start and clear the divider;
  - go to PLAY;
  - if track_end < track_start, go to DONE instead and pulse done the next cycle, with no samples.
- Divider:
  - counts 0 to CLK_DIV-1, only in PLAY;
  - a tick occurs in the cycle the count equals CLK_DIV-1, and the count then wraps to 0;
  - first tick is CLK_DIV cycles after start.
- On a tick in PLAY:
  - sample <= rom_data (rom_addr has been stable for at least CLK_DIV ≥ 2 cycles, which covers the 1-cycle ROM latency);
  - sample_stb = 1 for exactly that cycle.
- Address advance on the same tick:
  - if rom_addr != end_latched, rom_addr += 1;
  - else if loop_en, rom_addr <= start_latched and stay in PLAY;
  - else go to DONE and assert done for one cycle (the cycle after the tick); rom_addr holds end_latched.
- Address arithmetic is ADDR_W-bit unsigned. end = 2^ADDR_W-1 never overflows because the end compare happens before increment.
- Pause:
  - PLAY with pause=1 goes to PAUSE at the next edge;
  - divider count, rom_addr and sample are frozen; no ticks;
  - pause=0 returns to PLAY and resumes the count where it stopped.
- stop:
  - any state goes to IDLE;
  - sample <= 0, rom_addr <= 0, divider cleared;
  - no done pulse.
- DONE: sample holds the last value, playing = 0, and the state stays until start or stop.
- IDLE: sample = 0, playing = 0.
- rst mid-playback gives exactly the reset values on the next edge.
- One-sample window (start == end): one sample per tick; single-shot gives one stb then done; loop repeats the same address indefinitely.

Optional Feature:
- Macro SONG_VOLUME_EN.
- When defined:
  - adds input vol_shift (2 bits, level);
  - sample = registered ROM word logically right-shifted by vol_shift;
  - the shift is applied when sample loads; a change takes effect from the next tick.
- When undefined: no vol_shift port; sample is the unmodified ROM word.

Test Plan:
- CLK_DIV=4, ROM[a]=a[3:0], start with track_start=10, track_end=13, loop_en=0 -> sample_stb every 4 cycles; samples 10,11,12,13; done one cycle after the 4th stb; playing drops; sample holds 13.
- Same window with loop_en=1, run 10 ticks -> samples 10,11,12,13,10,11,12,13,10,11; no done pulse.
- Playing, pause high 9 cycles after 2nd stb -> no stb and rom_addr constant during pause; next stb arrives exactly 9 cycles later than unpaused.
- stop and start asserted in the same cycle mid-track -> IDLE, sample=0, rom_addr=0, no done; a later start alone -> first stb at cycle 4 with sample = ROM[track_start].
- track_start=20, track_end=5 -> no stb, DONE entered, single done pulse; start with end=2^15-1, start=2^15-2, loop_en=1 -> addresses 32766,32767,32766 with no overflow.
- SONG_VOLUME_EN defined, ROM word 12, vol_shift=2 -> sample=3; change vol_shift to 0 mid-interval -> next stb shows 12.

Source files
------------

// File: rtl/song_sample_player.sv
// rtl/song_sample_player.sv - stored-song sample playback engine (optional volume shift: SONG_VOLUME_EN)
module song_sample_player #(
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 4,
   parameter int CLK_DIV = 3125
) (
   input  logic              clk50Mghz,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] track_start,
   input  logic [ADDR_W-1:0] track_end,
`ifdef SONG_VOLUME_EN
   input  logic [1:0]        vol_shift,
`endif
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample,
   output logic              sample_stb,
   output logic              playing,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   state_t            state;
   logic [15:0]       div_cnt;
   logic [ADDR_W-1:0] start_l;
   logic [ADDR_W-1:0] end_l;
   logic              fin_pend;   // DONE entered; done pulses one cycle later
   logic [DATA_W-1:0] load_val;
   logic              tick;

   assign tick = (div_cnt == DIV_LAST);

   // value captured into sample on a tick, optionally attenuated
   always_comb begin
`ifdef SONG_VOLUME_EN
      load_val = rom_data >> vol_shift;
`else
      load_val = rom_data;
`endif
   end

   // playback control, divider, address stepping and registered outputs
   always_ff @(posedge clk50Mghz) begin
      if (rst) begin
         state      <= S_IDLE;
         rom_addr   <= '0;
         div_cnt    <= '0;
         sample     <= '0;
         sample_stb <= 1'b0;
         playing    <= 1'b0;
         done       <= 1'b0;
         fin_pend   <= 1'b0;
         start_l    <= '0;
         end_l      <= '0;
      end else begin
         sample_stb <= 1'b0;
         done       <= fin_pend;
         fin_pend   <= 1'b0;
         if (stop) begin
            state    <= S_IDLE;
            rom_addr <= '0;
            div_cnt  <= '0;
            sample   <= '0;
            playing  <= 1'b0;
            done     <= 1'b0;
         end else if (start) begin
            start_l  <= track_start;
            end_l    <= track_end;
            rom_addr <= track_start;
            div_cnt  <= '0;
            if (track_end < track_start) begin
               state    <= S_DONE;
               playing  <= 1'b0;
               fin_pend <= 1'b1;
            end else begin
               state   <= S_PLAY;
               playing <= 1'b1;
            end
         end else if (state == S_PLAY || state == S_PAUSE) begin
            if (pause) begin
               // everything frozen while paused
               state <= S_PAUSE;
            end else begin
               state <= S_PLAY;
               if (tick) begin
                  div_cnt    <= '0;
                  sample     <= load_val;
                  sample_stb <= 1'b1;
                  if (rom_addr != end_l) begin
                     rom_addr <= rom_addr + 1'b1;
                  end else if (loop_en) begin
                     rom_addr <= start_l;
                  end else begin
                     state    <= S_DONE;
                     playing  <= 1'b0;
                     fin_pend <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end
         end
      end
   end

endmodule
